// File: rtl/pattern_sequencer.sv
// pattern_sequencer
// Chooses which of eight stored 16x16 patterns the board displays, and runs
// the handshake that asks the board to copy the chosen pattern.
// The index moves forward or backward on a key press. It can also move
// forward on its own after a programmable dwell time. Each change of index
// starts a load request, which the board acknowledges. If no acknowledge
// arrives in time, the request is abandoned and a sticky error flag is set.
//
// Parameters
//   DWELL_CYCLES : idle cycles between automatic advances (>= 2)
//   ACK_TIMEOUT  : maximum cycles spent waiting for load_ack (>= 2)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   next_req in   debounced key level; a rising edge selects the next pattern
//   prev_req in   debounced key level; a rising edge selects the previous pattern
//   auto_en  in   enables automatic cycling through the patterns
//   load_ack in   board has copied the pattern on the mux output
//   select   out  registered 3-bit pattern mux select
//   load_req out  registered request asking the board to load the pattern
//   busy     out  high whenever the sequencer is not idle
//   load_err out  sticky flag, a load request timed out
module pattern_sequencer #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       next_req,
    input  logic       prev_req,
    input  logic       auto_en,
    input  logic       load_ack,
    output logic [2:0] select,
    output logic       load_req,
    output logic       busy,
    output logic       load_err
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int WW = $clog2(ACK_TIMEOUT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        START = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      select_q, select_d;
    logic            loadReq_q, loadReq_d;
    logic            loadErr_q, loadErr_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            nextKey_q, prevKey_q;
    logic            nextEdge, prevEdge;

    // The key history registers reset to 1. A key that is held down through
    // reset therefore looks already pressed, and releasing it later does not
    // produce a rising edge.
    assign nextEdge = next_req & ~nextKey_q;
    assign prevEdge = prev_req & ~prevKey_q;

    // State register and all registered outputs. The key history is updated
    // on every cycle, whatever the state. This means edges seen during START
    // or LOAD are thrown away rather than saved for later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= START;
            select_q  <= 3'd0;
            loadReq_q <= 1'b0;
            loadErr_q <= 1'b0;
            dwell_q   <= '0;
            wait_q    <= '0;
            nextKey_q <= 1'b1;
            prevKey_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            loadReq_q <= loadReq_d;
            loadErr_q <= loadErr_d;
            dwell_q   <= dwell_d;
            wait_q    <= wait_d;
            nextKey_q <= next_req;
            prevKey_q <= prev_req;
        end
    end

    // Next-state logic. Both counters default to zero. They keep counting
    // only on the paths that explicitly carry them forward. As a result, the
    // dwell count clears outside IDLE, and the wait count restarts on every
    // new entry into LOAD.
    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        loadErr_d = loadErr_q;
        dwell_d   = '0;
        wait_d    = '0;

        case (state_q)
            START: begin
                state_d = LOAD;
            end

            IDLE: begin
                // A manual press wins over a dwell expiry in the same cycle.
                // Pressing both keys together cancels out. It still restarts
                // the dwell time, because dwell_d stays at its default of 0.
                if (nextEdge && !prevEdge) begin
                    select_d = select_q + 3'd1;
                    state_d  = LOAD;
                end else if (prevEdge && !nextEdge) begin
                    select_d = select_q - 3'd1;
                    state_d  = LOAD;
                end else if (!nextEdge && !prevEdge && auto_en) begin
                    if (dwell_q == DWELL_LAST) begin
                        select_d = select_q + 3'd1;
                        state_d  = LOAD;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end

            LOAD: begin
                // If the acknowledge arrives in the last allowed cycle, the
                // load still counts as successful.
                if (load_ack) begin
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = IDLE;
                    loadErr_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            default: begin
                state_d = START;
            end
        endcase

        loadReq_d = (state_d == LOAD);
    end

    assign select   = select_q;
    assign load_req = loadReq_q;
    assign load_err = loadErr_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer
// Directed bench for pattern_sequencer, with DWELL_CYCLES=16 and ACK_TIMEOUT=8.
// A reference model describes the required behaviour at the pattern and
// mode level. It is compared against the DUT outputs on every falling edge.
// Hand-computed literal checks pin down the key scenarios.
module tb_pattern_sequencer;

   localparam int DWELL = 16;
   localparam int ACK   = 8;

   localparam int M_START = 0;
   localparam int M_IDLE  = 1;
   localparam int M_LOAD  = 2;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       next_req = 1'b0;
   logic       prev_req = 1'b0;
   logic       auto_en  = 1'b0;
   logic       load_ack = 1'b1;
   logic [2:0] select;
   logic       load_req;
   logic       busy;
   logic       load_err;

   int checks   = 0;
   int failures = 0;

   pattern_sequencer #(
      .DWELL_CYCLES(DWELL),
      .ACK_TIMEOUT (ACK)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .next_req(next_req),
      .prev_req(prev_req),
      .auto_en (auto_en),
      .load_ack(load_ack),
      .select  (select),
      .load_req(load_req),
      .busy    (busy),
      .load_err(load_err)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Reference model state. The mode says which phase the sequencer is in.
   // mSel is the pattern number and mLoadCycles counts completed waiting
   // cycles of the current load.
   int mMode       = M_START;
   int mSel        = 0;
   int mDwell      = 0;
   int mLoadCycles = 0;
   bit mErr        = 1'b0;
   bit mNextPrev   = 1'b1;
   bit mPrevPrev   = 1'b1;
   bit mValid      = 1'b0;
   bit mNextEdge;
   bit mPrevEdge;

   assign mNextEdge = next_req && !mNextPrev;
   assign mPrevEdge = prev_req && !mPrevPrev;

   // Behavioural model: on each rising edge, apply the rules for the current
   // phase to the pattern number, the dwell timer and the load timer.
   always @(posedge clk) begin
      if (reset) begin
         mMode       <= M_START;
         mSel        <= 0;
         mDwell      <= 0;
         mLoadCycles <= 0;
         mErr        <= 1'b0;
         mNextPrev   <= 1'b1;
         mPrevPrev   <= 1'b1;
         mValid      <= 1'b1;
      end else begin
         mNextPrev <= next_req;
         mPrevPrev <= prev_req;
         case (mMode)
            M_START: begin
               mMode       <= M_LOAD;
               mLoadCycles <= 0;
            end
            M_IDLE: begin
               if (mNextEdge && mPrevEdge) begin
                  mDwell <= 0;
               end else if (mNextEdge || mPrevEdge) begin
                  mSel        <= mNextEdge ? (mSel + 1) % 8 : (mSel + 7) % 8;
                  mMode       <= M_LOAD;
                  mLoadCycles <= 0;
                  mDwell      <= 0;
               end else if (!auto_en) begin
                  mDwell <= 0;
               end else if (mDwell + 1 == DWELL) begin
                  mSel        <= (mSel + 1) % 8;
                  mMode       <= M_LOAD;
                  mLoadCycles <= 0;
                  mDwell      <= 0;
               end else begin
                  mDwell <= mDwell + 1;
               end
            end
            default: begin
               if (load_ack) begin
                  mMode <= M_IDLE;
               end else if (mLoadCycles + 1 == ACK) begin
                  mMode <= M_IDLE;
                  mErr  <= 1'b1;
               end else begin
                  mLoadCycles <= mLoadCycles + 1;
               end
            end
         endcase
      end
   end

   // Counts one comparison. On a mismatch, prints a FAIL line that names
   // the check.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d time=%0t",
                  name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle compare against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (mValid) begin
         checkOutput("model select", {29'd0, select}, mSel);
         checkOutput("model load_req", {31'd0, load_req}, (mMode == M_LOAD) ? 1 : 0);
         checkOutput("model busy", {31'd0, busy}, (mMode != M_IDLE) ? 1 : 0);
         checkOutput("model load_err", {31'd0, load_err}, {31'd0, mErr});
      end
   end

   // Waits n rising edges, then moves 2 time units past the edge. Inputs
   // are driven at that point.
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Drives one single-cycle key pulse, with one or both keys.
   task automatic applyStimulus(input logic nextV, input logic prevV);
      @(posedge clk);
      #2;
      next_req = nextV;
      prev_req = prevV;
      @(posedge clk);
      #2;
      next_req = 1'b0;
      prev_req = 1'b0;
   endtask

   // Counts the falling edges, within a window of n, on which load_req is high.
   task automatic countLoadReq(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (load_req) cnt++;
      end
   endtask

   // Waits, up to a bounded number of falling edges, for select to equal v.
   task automatic waitForSelect(input logic [2:0] v, input int limit, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (select !== v && cycles < limit);
   endtask

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenario sequence.
   initial begin
      int n;
      int cyc;

      // Boot with load_ack tied high: expect one load of pattern 0, then idle.
      reset    = 1'b1;
      load_ack = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      countLoadReq(6, n);
      checkOutput("boot load pulses", n, 1);
      checkOutput("boot select", {29'd0, select}, 0);
      checkOutput("boot busy", {31'd0, busy}, 0);

      // Eight acknowledged next presses walk 1..7 and wrap to 0. Then prev wraps to 7.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0);
         waitCycles(3);
         checkOutput("next walk", {29'd0, select}, (i + 1) % 8);
      end
      applyStimulus(1'b0, 1'b1);
      waitCycles(3);
      checkOutput("prev wrap", {29'd0, select}, 7);

      // Automatic cycling: each advance takes 16 idle cycles plus 1 load cycle.
      auto_en = 1'b1;
      waitForSelect(3'd0, 40, cyc);
      checkOutput("auto first advance", {29'd0, select}, 0);
      waitForSelect(3'd1, 40, cyc);
      checkOutput("auto period", cyc, 17);
      checkOutput("auto second advance", {29'd0, select}, 1);
      // A next press lands exactly on the following auto advance.
      repeat (16) @(posedge clk);
      #2;
      next_req = 1'b1;
      @(posedge clk);
      #2;
      next_req = 1'b0;
      waitCycles(3);
      auto_en = 1'b0;
      waitCycles(2);
      checkOutput("auto collision", {29'd0, select}, 2);

      // No acknowledge: the request stays up for 8 cycles, then times out.
      load_ack = 1'b0;
      applyStimulus(1'b1, 1'b0);
      countLoadReq(15, n);
      checkOutput("timeout load_req cycles", n, 8);
      checkOutput("timeout load_err", {31'd0, load_err}, 1);
      checkOutput("timeout busy", {31'd0, busy}, 0);
      checkOutput("timeout select", {29'd0, select}, 3);

      // Both keys pressed together are ignored.
      load_ack = 1'b1;
      applyStimulus(1'b1, 1'b1);
      countLoadReq(5, n);
      checkOutput("both keys load_req", n, 0);
      checkOutput("both keys select", {29'd0, select}, 3);

      // A press made during a load is dropped.
      load_ack = 1'b0;
      applyStimulus(1'b1, 1'b0);
      waitCycles(1);
      applyStimulus(1'b1, 1'b0);
      load_ack = 1'b1;
      waitCycles(4);
      checkOutput("press in load dropped", {29'd0, select}, 4);

      // A key held through reset gives no advance when it is released.
      next_req = 1'b1;
      reset    = 1'b1;
      waitCycles(3);
      reset = 1'b0;
      waitCycles(5);
      next_req = 1'b0;
      waitCycles(4);
      checkOutput("held key select", {29'd0, select}, 0);
      checkOutput("held key busy", {31'd0, busy}, 0);
      checkOutput("reset clears load_err", {31'd0, load_err}, 0);

      // Reset in the middle of a load aborts it. A fresh load of pattern 0 follows.
      load_ack = 1'b0;
      applyStimulus(1'b1, 1'b0);
      waitCycles(1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort load_req", {31'd0, load_req}, 0);
      checkOutput("abort select", {29'd0, select}, 0);
      checkOutput("abort busy", {31'd0, busy}, 1);
      checkOutput("abort load_err", {31'd0, load_err}, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (load_req !== 1'b1 && cyc < 5);
      checkOutput("fresh start load_req", {31'd0, load_req}, 1);
      checkOutput("fresh start select", {29'd0, select}, 0);
      load_ack = 1'b1;
      waitCycles(3);
      checkOutput("fresh start idle", {31'd0, busy}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
